// File: rtl/scan_test_ctrl.sv
// Scan-chain test sequencer: loads patterns over valid/ready, shifts them through the
// chain, captures, unloads responses and counts mismatches against expected vectors.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned FAIL_W    = 8,
  parameter int unsigned IDX_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] exp_data,
  input  logic                 pat_last,
  output logic                 si,
  output logic                 se,
  input  logic                 so,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [FAIL_W-1:0]    fail_cnt,
  output logic [IDX_W-1:0]     first_fail
);

  localparam int unsigned CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_CMP,
    S_DONE
  } state_t;

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CHAIN_LEN-1:0] stim, stim_n;
  logic [CHAIN_LEN-1:0] resp_shift, resp_n;
  logic [CHAIN_LEN-1:0] exp_nxt, exp_nxt_n;
  logic [CHAIN_LEN-1:0] exp_cur, exp_cur_n;
  logic                 last_flag, last_n;
  logic                 resp_pending, pend_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [FAIL_W-1:0]    fail_cnt_n;
  logic [IDX_W-1:0]     first_fail_n;
  logic                 si_n, se_n, ready_n, busy_n, done_n, pass_n;
  logic                 take, do_cmp, hs, cnt_last;

  assign hs       = pat_valid & pat_ready;
  assign cnt_last = (cnt == CNT_W'(CHAIN_LEN - 1));

  // State and datapath registers; outputs are registered from their next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      stim         <= '0;
      resp_shift   <= '0;
      exp_nxt      <= '0;
      exp_cur      <= '0;
      last_flag    <= 1'b0;
      resp_pending <= 1'b0;
      idx          <= '0;
      fail_cnt     <= '0;
      first_fail   <= '1;
      si           <= 1'b0;
      se           <= 1'b0;
      pat_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= cnt_n;
      stim         <= stim_n;
      resp_shift   <= resp_n;
      exp_nxt      <= exp_nxt_n;
      exp_cur      <= exp_cur_n;
      last_flag    <= last_n;
      resp_pending <= pend_n;
      idx          <= idx_n;
      fail_cnt     <= fail_cnt_n;
      first_fail   <= first_fail_n;
      si           <= si_n;
      se           <= se_n;
      pat_ready    <= ready_n;
      busy         <= busy_n;
      done         <= done_n;
      pass         <= pass_n;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    next_state   = state;
    cnt_n        = '0;
    stim_n       = stim;
    resp_n       = resp_shift;
    exp_nxt_n    = exp_nxt;
    exp_cur_n    = exp_cur;
    last_n       = last_flag;
    pend_n       = resp_pending;
    idx_n        = idx;
    fail_cnt_n   = fail_cnt;
    first_fail_n = first_fail;
    take         = 1'b0;
    do_cmp       = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          next_state   = S_LOAD;
          fail_cnt_n   = '0;
          first_fail_n = '1;
          idx_n        = '0;
          pend_n       = 1'b0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          take       = 1'b1;
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        resp_n = {resp_shift[CHAIN_LEN-2:0], so};
        stim_n = stim << 1;
        if (cnt_last) next_state = S_CAPTURE;
        else          cnt_n      = cnt + CNT_W'(1);
      end
      S_CAPTURE: begin
        // Any owed compare of the previous pattern is folded into this cycle.
        pend_n    = 1'b1;
        exp_cur_n = exp_nxt;
        do_cmp    = resp_pending;
        if (last_flag) begin
          next_state = S_UNLOAD;
        end else if (hs) begin
          take       = 1'b1;
          next_state = S_SHIFT;
        end else begin
          next_state = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        resp_n = {resp_shift[CHAIN_LEN-2:0], so};
        if (cnt_last) next_state = S_CMP;
        else          cnt_n      = cnt + CNT_W'(1);
      end
      S_CMP: begin
        do_cmp     = 1'b1;
        pend_n     = 1'b0;
        next_state = last_flag ? S_DONE : S_LOAD;
      end
      default: next_state = S_IDLE;
    endcase

    if (take) begin
      stim_n    = pat_data;
      exp_nxt_n = exp_data;
      last_n    = pat_last;
    end

    if (do_cmp) begin
      idx_n = idx + IDX_W'(1);
      if (resp_shift != exp_cur) begin
        if (fail_cnt != '1) fail_cnt_n = fail_cnt + FAIL_W'(1);
        if (fail_cnt == '0) first_fail_n = idx;
      end
    end

    se_n    = (next_state == S_SHIFT) || (next_state == S_UNLOAD);
    si_n    = (next_state == S_SHIFT) ? stim_n[CHAIN_LEN-1] : 1'b0;
    ready_n = (next_state == S_LOAD) || ((next_state == S_CAPTURE) && !last_n);
    busy_n  = (next_state != S_IDLE) && (next_state != S_DONE);
    done_n  = (next_state == S_DONE);
    pass_n  = (next_state == S_DONE) && (fail_cnt_n == '0);
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl with a behavioural scan chain and an SI scoreboard.
module tb_scan_test_ctrl;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         pat_valid = 1'b0;
  logic         pat_last = 1'b0;
  logic [N-1:0] pat_data = '0;
  logic [N-1:0] exp_data = '0;
  logic         pat_ready, si, se, so, busy, done, pass;
  logic [7:0]   fail_cnt, first_fail;

  logic [N-1:0] chain = '0;
  logic [N-1:0] sq[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           busy_total = 0;
  int           m_fail, m_idx;
  logic [7:0]   m_first;
  bit           m_any;

  scan_test_ctrl #(.CHAIN_LEN(N), .FAIL_W(8), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .exp_data(exp_data), .pat_last(pat_last), .si(si), .se(se), .so(so),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt), .first_fail(first_fail)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] cap(input logic [N-1:0] x);
    return {x[N-2:0], x[N-1]} ^ N'(5);
  endfunction

  // Scan-wrapped CUT model: shift when se=1, capture cap(chain) otherwise.
  always @(posedge clk) chain <= se ? {chain[N-2:0], si} : cap(chain);
  assign so = chain[N-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Pops a pattern for each SE-high streak that follows a handshake; other streaks must shift zeros.
  task automatic monitor();
    logic [N-1:0] cur = '0;
    bit prev_se = 0, hs_prev = 0, shift_streak = 0;
    int pos = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sq.delete();
        prev_se = 0; hs_prev = 0; shift_streak = 0; pos = 0;
      end else begin
        if (busy) busy_total++;
        if (se) begin
          if (!prev_se) begin
            pos = 0; shift_streak = hs_prev; cur = '0;
            if (hs_prev) begin
              chk("sb_depth", 32'(sq.size()), 32'd1);
              if (sq.size() > 0) cur = sq.pop_front();
            end
          end
          chk(shift_streak ? "si_stim" : "si_unload", 32'(si), 32'(cur[N-1]));
          cur = cur << 1;
          pos++;
        end else if (prev_se) begin
          chk("se_len", 32'(pos), 32'(N));
        end
        prev_se = se;
        hs_prev = pat_valid && pat_ready;
        if (hs_prev) sq.push_back(pat_data);
      end
    end
  endtask

  task automatic do_start();
    m_fail = 0; m_idx = 0; m_first = 8'hFF; m_any = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] p, input logic [N-1:0] e, input logic l);
    bit got = 0;
    pat_data = p; exp_data = e; pat_last = l; pat_valid = 1'b1;
    if (cap(p) != e) begin
      if (m_fail != 255) m_fail++;
      if (!m_any) m_first = 8'(m_idx);
      m_any = 1;
    end
    m_idx++;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk); got = pat_ready;
      @(posedge clk); #1;
      if (got) break;
    end
    chk("hs_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    pat_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    chk({tag, "_first_fail"}, 32'(first_fail), 32'(m_first));
    chk({tag, "_pass"}, 32'(pass), 32'(m_fail == 0));
  endtask

  initial begin
    int b0;
    logic [N-1:0] p;
    fork monitor(); join_none

    // Reset state
    @(negedge clk);
    chk("rst_se", 32'(se), 32'd0);
    chk("rst_si", 32'(si), 32'd0);
    chk("rst_ready", 32'(pat_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_first_fail", 32'(first_fail), 32'hFF);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single passing pattern
    do_start(); b0 = busy_total;
    send(4'b1011, cap(4'b1011), 1'b1);
    wait_done();
    chk("t1_busy_cycles", 32'(busy_total - b0), 32'd11);
    chk_result("t1");

    // Three back-to-back patterns, pattern 1 corrupted in bit 2
    do_start(); b0 = busy_total;
    send(4'b1011, cap(4'b1011), 1'b0);
    send(4'b0110, cap(4'b0110) ^ 4'b0100, 1'b0);
    send(4'b1100, cap(4'b1100), 1'b1);
    wait_done();
    chk("t2_busy_cycles", 32'(busy_total - b0), 32'd21);
    chk_result("t2");

    // Source stalls after pattern 0: unload and compare, then wait in LOAD
    do_start();
    send(4'b0011, cap(4'b0011), 1'b0);
    pat_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("t3_ready_wait", 32'(pat_ready), 32'd1);
    chk("t3_busy_wait", 32'(busy), 32'd1);
    chk("t3_se_wait", 32'(se), 32'd0);
    chk("t3_fail_cnt_wait", 32'(fail_cnt), 32'd0);
    @(posedge clk); #1;
    send(4'b1110, cap(4'b1110), 1'b0);
    send(4'b0101, cap(4'b0101), 1'b1);
    wait_done();
    chk_result("t3");

    // 300 failing patterns: counter saturates
    do_start();
    for (int i = 0; i < 300; i++) begin
      p = N'($urandom_range(0, 15));
      send(p, ~cap(p), 1'(i == 299));
    end
    wait_done();
    chk_result("t4");

    // Reset during SHIFT of pattern 2, then a clean rerun
    do_start();
    send(4'b1001, ~cap(4'b1001), 1'b0);
    send(4'b0111, cap(4'b0111), 1'b0);
    send(4'b1010, cap(4'b1010), 1'b0);
    chk("t5_pre_fail_cnt", 32'(fail_cnt), 32'd1);
    chk("t5_pre_se", 32'(se), 32'd1);
    #1 rst_n = 1'b0;
    pat_valid = 1'b0;
    #1;
    chk("t5_rst_se", 32'(se), 32'd0);
    chk("t5_rst_si", 32'(si), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("t5_rst_first_fail", 32'(first_fail), 32'hFF);
    @(posedge clk); #1 rst_n = 1'b1;
    do_start();
    send(4'b0001, ~cap(4'b0001), 1'b0);
    send(4'b1000, cap(4'b1000), 1'b1);
    wait_done();
    chk_result("t5");

    // START during SHIFT is ignored; START in DONE restarts and clears
    do_start(); b0 = busy_total;
    send(4'b1101, cap(4'b1101), 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    send(4'b0100, cap(4'b0100) ^ 4'b0001, 1'b1);
    wait_done();
    chk("t6_busy_cycles", 32'(busy_total - b0), 32'd16);
    chk_result("t6");
    do_start();
    @(negedge clk);
    chk("t6_restart_done", 32'(done), 32'd0);
    chk("t6_restart_busy", 32'(busy), 32'd1);
    chk("t6_restart_ready", 32'(pat_ready), 32'd1);
    chk("t6_restart_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("t6_restart_first_fail", 32'(first_fail), 32'hFF);
    @(posedge clk); #1;
    send(4'b0110, cap(4'b0110), 1'b1);
    wait_done();
    chk_result("t6b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
- Sequences one scan-chain test wrapper: drives SI/SE, receives SO, runs shift/capture/unload per pattern.
- Patterns and expected responses arrive from a pattern source over a valid/ready handshake.
- Each unloaded response is compared with its expected vector; failures are counted.
- Sits between the test-pattern source (BIST ROM or testbench) and the scan-wrapped CUT.

Parameters:
- CHAIN_LEN, 4, number of scan flops in the chain (2..32).
- FAIL_W, 8, width of the saturating failure counter.
- IDX_W, 8, width of the pattern index and failure-index registers.

Ports:
- CLK  in  1  clock; also clocks the scan chain.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse that begins a test run; ignored unless the FSM is in IDLE or DONE.
- PAT_VALID  in  1  pattern source has a pattern.
- PAT_READY  out  1  controller accepts the pattern this cycle.
- PAT_DATA  in  CHAIN_LEN  stimulus; bit CHAIN_LEN-1 is destined for the flop nearest SO.
- EXP_DATA  in  CHAIN_LEN  expected captured response, same bit mapping as PAT_DATA.
- PAT_LAST  in  1  marks the final pattern; qualified by the handshake.
- SI  out  1  scan input to the chain.
- SE  out  1  scan enable: 1 = shift, 0 = capture.
- SO  in  1  scan output from the chain.
- BUSY  out  1  high in every state except IDLE and DONE.
- DONE  out  1  level; high in DONE until the next START.
- PASS  out  1  valid while DONE=1; 1 if and only if FAIL_CNT=0.
- FAIL_CNT  out  FAIL_W  mismatching patterns; saturates at all-ones.
- FIRST_FAIL  out  IDX_W  index of the first failing pattern (0-based); all-ones if none.

Behaviour:
- Reset (async, RST_N=0): state IDLE, SE=0, SI=0, PAT_READY=0, BUSY=0, DONE=0, PASS=0, FAIL_CNT=0, FIRST_FAIL=all-ones, internal pattern index=0, resp_pending=0.
- Reset mid-run aborts immediately. No partial result is retained.
- States: IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, CMP, DONE.
- IDLE/DONE + START: clear FAIL_CNT, FIRST_FAIL and the index; clear DONE; go to LOAD.
- LOAD:
  - PAT_READY=1, SE=0.
  - On PAT_VALID & PAT_READY: latch PAT_DATA into the stimulus register, EXP_DATA into exp_next, and PAT_LAST into last_flag; go to SHIFT.
  - SE=0 in LOAD is harmless because the chain contents are fully overwritten by the next shift.
- SHIFT: exactly CHAIN_LEN cycles with SE=1.
  - SI presents stimulus bit CHAIN_LEN-1 first, down to bit 0.
  - At each rising edge the controller samples SO (the value before the shift) into resp_shift, MSB first. After CHAIN_LEN cycles resp_shift[CHAIN_LEN-1] = value captured in the flop nearest SO.
  - If resp_pending=1, the response collected here belongs to the previous pattern; go to CMP-then-CAPTURE (CMP takes 1 cycle with SE=0, which is the capture cycle, see below). Otherwise go to CAPTURE.
- CAPTURE: 1 cycle, SE=0, SI=0.
  - Chain captures the CUT response. Set resp_pending=1 and copy exp_next to exp_cur.
  - If a comparison is owed, perform it in this same cycle; CMP and CAPTURE are merged, so a separate CMP state is used only after UNLOAD.
  - Next state:
    - If last_flag=1, go to UNLOAD.
    - Else if PAT_VALID=1, go to SHIFT. PAT_READY=1 in this cycle accepts the next pattern with zero bubble, giving an overlapped unload.
    - Else go to UNLOAD.
- UNLOAD: CHAIN_LEN cycles, SE=1, SI=0; SO is collected as in SHIFT. Then go to CMP.
- CMP: 1 cycle, SE=0.
  - Compare resp_shift against exp_cur and clear resp_pending.
  - Then go to DONE if last_flag=1, else go to LOAD.
- Compare rule:
  - Mismatch if any bit differs.
  - On mismatch, FAIL_CNT increments (saturating). If this is the first failure, FIRST_FAIL is set to the index of the pattern whose response was compared.
  - The pattern index increments on every compare.
- DONE: BUSY=0, DONE=1, PASS=(FAIL_CNT==0), SE=0, PAT_READY=0.
- Simultaneous events:
  - START outside IDLE/DONE is ignored.
  - PAT_VALID outside LOAD/CAPTURE is not acknowledged.
  - PAT_DATA/EXP_DATA are sampled only on a handshake.
- Index wraps modulo 2^IDX_W. FIRST_FAIL reports the wrapped value.
- Latency: pattern accepted to its compare = CHAIN_LEN+1+CHAIN_LEN(+1 for CMP when unloaded) cycles.

Test Plan:
- Single pattern, CHAIN_LEN=4: PAT_DATA=4'b1011, EXP_DATA equal to the model capture, PAT_LAST=1 → SI sequence 1,0,1,1 with SE high 4 cycles; SE low 1 cycle; 4 unload cycles; DONE=1, PASS=1, FAIL_CNT=0, FIRST_FAIL=8'hFF.
- Three back-to-back patterns with PAT_VALID held high, pattern 1 expected value corrupted in bit 2 → no LOAD bubbles between patterns, SE low exactly once per pattern, FAIL_CNT=1, FIRST_FAIL=1, PASS=0.
- PAT_VALID dropped for 5 cycles after pattern 0's capture → UNLOAD with SI=0 and compare of pattern 0 occur; controller waits in LOAD with PAT_READY=1; run resumes correctly with 0 failures.
- All 300 patterns failing, FAIL_W=8 → FAIL_CNT saturates at 255; FIRST_FAIL=0.
- RST_N asserted during SHIFT of pattern 2 → SE, SI, BUSY, DONE and FAIL_CNT are 0 in the same cycle; a subsequent START runs cleanly from index 0.
- START pulsed during SHIFT → ignored; run completes unchanged. START in DONE → DONE drops next cycle and counters clear.
